// File: rtl/stream_tx_pkg.sv
// Shared types and constants for the stream_tx burst generator.
package stream_tx_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_DIV_WIDTH  = 16;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stream_tx_lfsr.sv
// Galois right-shift LFSR step plus zero-seed replacement; purely combinational.
module stream_tx_lfsr
  import stream_tx_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] seed_fixed,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(LFSR_MASK);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // An all-zero state would lock the register, so a zero seed becomes 1.
  always_comb begin
    if (seed == {WIDTH{1'b0}}) begin
      seed_fixed = ONE;
    end else begin
      seed_fixed = seed;
    end
    if (state[0]) begin
      next = (state >> 1) ^ MASK;
    end else begin
      next = state >> 1;
    end
  end

endmodule

// File: rtl/stream_tx.sv
// Bounded-burst stream source with ce pacing; STREAM_TX_LFSR_EN adds the LFSR pattern.
module stream_tx
  import stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DIV_WIDTH-1:0]  divider,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ce,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [LEN_WIDTH-1:0]  length_r;
  logic [DIV_WIDTH-1:0]  divider_r;
  logic [DIV_WIDTH-1:0]  div_cnt_r;
  logic [LEN_WIDTH-1:0]  sent_r;
  logic [DATA_WIDTH-1:0] first_word_s;
  logic [DATA_WIDTH-1:0] next_word_s;
  logic                  accept_s;

  assign accept_s = (state_r == IDLE) && start;

`ifdef STREAM_TX_LFSR_EN
  logic                  mode_r;
  logic [DATA_WIDTH-1:0] lfsr_seed_s;
  logic [DATA_WIDTH-1:0] lfsr_next_s;

  stream_tx_lfsr #(.WIDTH(DATA_WIDTH)) u_lfsr (
    .seed       (seed),
    .state      (data_out),
    .seed_fixed (lfsr_seed_s),
    .next       (lfsr_next_s)
  );

  // Pattern select is captured with the accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r <= 1'b0;
    end else if (accept_s) begin
      mode_r <= mode;
    end else begin
      mode_r <= mode_r;
    end
  end

  // The next word is always derived from the word currently on data_out.
  always_comb begin
    if (mode) begin
      first_word_s = lfsr_seed_s;
    end else begin
      first_word_s = seed;
    end
    if (mode_r) begin
      next_word_s = lfsr_next_s;
    end else begin
      next_word_s = data_out + DATA_ONE;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  // Ramp only: the next word is the current word plus one.
  always_comb begin
    first_word_s = seed;
    next_word_s  = data_out + DATA_ONE;
  end
`endif

  // Burst FSM with word and divider counters; all outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      length_r  <= {LEN_WIDTH{1'b0}};
      divider_r <= {DIV_WIDTH{1'b0}};
      div_cnt_r <= {DIV_WIDTH{1'b0}};
      sent_r    <= {LEN_WIDTH{1'b0}};
      data_out  <= {DATA_WIDTH{1'b0}};
      ce        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ce   <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            length_r  <= length;
            divider_r <= divider;
            if (length != {LEN_WIDTH{1'b0}}) begin
              state_r   <= RUN;
              ce        <= 1'b1;
              busy      <= 1'b1;
              data_out  <= first_word_s;
              div_cnt_r <= divider;
              sent_r    <= LEN_ONE;
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          // sent_r counts the strobe already on ce, so equality means the last word is out.
          if (abort || (sent_r == length_r)) begin
            state_r <= DONE;
            ce      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (div_cnt_r == {DIV_WIDTH{1'b0}}) begin
            ce        <= 1'b1;
            data_out  <= next_word_s;
            sent_r    <= sent_r + LEN_ONE;
            div_cnt_r <= divider_r;
          end else begin
            ce        <= 1'b0;
            div_cnt_r <= div_cnt_r - DIV_ONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
          ce      <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ce      <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stream_tx.md
# stream_tx

Stream transmitter that drives the ce-strobed 32-bit data interface consumed by the team's example data-path modules (`data_in` + `ce`). It generates a bounded burst of words, either a ramp or an optional LFSR pattern. A programmable divider paces the `ce` strobe. The block sits upstream of any `data_in`/`ce` consumer and serves as a bring-up and test source on the same clock.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `data_out` and `seed`.
- `LEN_WIDTH`, 16: width of `length`.
- `DIV_WIDTH`, 16: width of `divider`.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `abort`  in  1  terminates a burst in progress.
- `length`  in  LEN_WIDTH  number of words in the burst, unsigned.
- `divider`  in  DIV_WIDTH  `ce` period minus 1, in cycles, unsigned.
- `seed`  in  DATA_WIDTH  first word of the burst.
- `mode`  in  1  pattern select: 0 = ramp, 1 = LFSR (only when compiled in).
- `data_out`  out  DATA_WIDTH  output word; connects to the consumer's `data_in`.
- `ce`  out  1  data strobe; one cycle per word.
- `busy`  out  1  high while a burst is running.
- `done`  out  1  one-cycle pulse at the end of a burst (normal or aborted).

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN on `start` with `length` != 0.
- IDLE -> DONE on `start` with `length` == 0; no `ce` is issued.
- RUN -> DONE after the `length`-th `ce`, or on `abort`.
- DONE -> IDLE unconditionally, after one cycle.
- `length`, `divider`, `seed` and `mode` are latched on the accepted `start`. Changes to these inputs during RUN have no effect.
- Ramp pattern: word k = `seed` + k, modulo 2^DATA_WIDTH, so it wraps silently.
- LFSR pattern (32-bit Galois, right shift): word 0 = `seed`, with a zero seed replaced by 1. Next word = (s >> 1) XOR (s[0] ? 32'h80200003 : 0).
- `data_out` updates only together with `ce` and holds its value between strobes and after the burst.
- A `start` during RUN or DONE is ignored and not queued.
- `abort` in the same cycle as a `ce`: that word is delivered, then the FSM goes to DONE.
- `abort` in IDLE has no effect.
- `rst` at any time returns the FSM to IDLE and clears all internal counters and outputs.
- Reset values: `data_out` = 0, `ce` = 0, `busy` = 0, `done` = 0.

## Timing
- All outputs are registered.
- Let `start` be accepted in cycle N, with L = `length` and D = `divider`.
- `busy` is high from cycle N+1 until the last `ce` cycle, inclusive.
- First `ce` is in cycle N+1. Word k is strobed in cycle N+1+k·(D+1), for k = 0..L-1.
- D = 0 gives `ce` on every cycle of the burst.
- `done` pulses in the cycle after the last `ce`. For L = 0, `done` pulses in cycle N+1 and `busy` stays low.
- `abort` sampled in cycle M during RUN: no `ce` after cycle M, `busy` low from M+1, `done` in M+1.
- Earliest next accepted `start` is in the cycle after `done`.
- The divider counter is DIV_WIDTH bits. It reloads to D on each `ce` and counts down to 0.

## Configuration
- Macro: `STREAM_TX_LFSR_EN`.
- Defined: LFSR generator is present and `mode` = 1 selects it.
- Undefined: LFSR logic is absent, `mode` is ignored and the ramp pattern is always used. The port list is unchanged.

## Structure
- Shared package `stream_tx_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - `LFSR_MASK` = 32'h80200003.
  - Default widths.
- Sub-module `stream_tx_lfsr`: one-step next-state function plus a zero-seed fix. Instantiated only under `STREAM_TX_LFSR_EN`.
- Divider counter, word counter and FSM stay in `stream_tx`.

## Test plan
- L=4, D=0, seed=0x10, ramp -> `ce` in N+1..N+4 with `data_out` 0x10, 0x11, 0x12, 0x13; `done` in N+5; `busy` N+1..N+4.
- L=3, D=2, seed=0xFFFFFFFE, ramp -> `ce` in N+1, N+4, N+7 with 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; `done` in N+8.
- L=0 -> no `ce`, `busy` stays 0, `done` in N+1; a second `start` in N+1 is ignored.
- `STREAM_TX_LFSR_EN`, mode=1, seed=0, L=3, D=0 -> words 0x00000001, 0x80200003, 0xC0300002.
- L=10, D=1, `abort` in the cycle of the 3rd `ce` -> exactly 3 strobes, `done` one cycle later, `data_out` holds the 3rd word.
- `rst` mid-burst, then `start` -> all outputs 0 the cycle after `rst`; the new burst begins cleanly from its own seed.
